tt_um_accum_alu: RTL and testbench

//  Pipelined, parametrised adder/accumulator for the tile top-level: accepts operand pairs over a

---
 rtl/tt_accum_alu_pkg.sv | 18 +
 rtl/accum_alu_addsub.sv | 50 +++++
 rtl/tt_um_accum_alu.sv | 96 +++++++++
 tb/tb_tt_um_accum_alu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_accum_alu_pkg.sv
// rtl/tt_accum_alu_pkg.sv - shared operation and result-register types for the accumulator ALU
package tt_accum_alu_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ACC = 2'd2,
      OP_CLR = 2'd3
   } op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } res_state_e;

endpackage

// File: rtl/accum_alu_addsub.sv
// rtl/accum_alu_addsub.sv - combinational add/sub with carry/borrow, signed overflow
// and optional clamping when ACCUM_ALU_SAT_EN is defined.
module accum_alu_addsub
   import tt_accum_alu_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic [OP_W-1:0]  i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_ovf
);

   op_e              w_op;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic             w_raw_carry;
   logic             w_raw_ovf;

   assign w_op    = op_e'(i_op);
   // Subtraction is a + ~b + 1, so the carry out is the inverse of the borrow.
   assign w_cin   = (w_op == OP_SUB);
   assign w_b_eff = (w_op == OP_SUB) ? ~i_b : i_b;
   assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

   assign w_raw_carry = (w_op == OP_SUB) ? ~w_sum[WIDTH] : w_sum[WIDTH];
   assign w_raw_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != i_a[WIDTH-1]);

   always_comb begin
      o_result = w_sum[WIDTH-1:0];
      o_carry  = w_raw_carry;
      o_ovf    = w_raw_ovf;
`ifdef ACCUM_ALU_SAT_EN
      if (w_raw_carry) begin
         o_result = (w_op == OP_SUB) ? '0 : '1;
      end
`endif
      if (w_op == OP_CLR) begin
         o_result = '0;
         o_carry  = 1'b0;
         o_ovf    = 1'b0;
      end
   end

endmodule

// File: rtl/tt_um_accum_alu.sv
// rtl/tt_um_accum_alu.sv - handshaked add/sub/accumulate unit with one result register,
// accumulator and beat counter; clamping enabled by ACCUM_ALU_SAT_EN.
module tt_um_accum_alu
   import tt_accum_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [CNT_W-1:0] op_count
);

   res_state_e       r_state;
   res_state_e       w_state_nxt;
   logic [WIDTH-1:0] r_data;
   logic             r_carry;
   logic             r_ovf;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;

   op_e              w_op;
   logic             w_accept;
   logic [WIDTH-1:0] w_b_sel;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_ovf;

   assign w_op     = op_e'(in_op);
   assign in_ready = (r_state == ST_EMPTY) || out_ready;
   assign w_accept = in_valid && in_ready;
   // ACC reuses the adder with the accumulator in place of operand B.
   assign w_b_sel  = (w_op == OP_ACC) ? r_acc : in_b;

   accum_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .i_op     (in_op),
      .i_a      (in_a),
      .i_b      (w_b_sel),
      .o_result (w_res),
      .o_carry  (w_carry),
      .o_ovf    (w_ovf)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_data  <= w_res;
         r_carry <= w_carry;
         r_ovf   <= w_ovf;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_op == OP_ACC || w_op == OP_CLR) begin
            r_acc <= w_res;
         end
      end
   end

   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_data;
   assign out_carry = r_carry;
   assign out_ovf   = r_ovf;
   assign op_count  = r_cnt;

endmodule

// File: tb/tb_tt_um_accum_alu.sv
// tb/tb_tt_um_accum_alu.sv - randomized self-checking bench for tt_um_accum_alu (WIDTH=8, CNT_W=8)
module tb_tt_um_accum_alu;
   import tt_accum_alu_pkg::*;

   localparam int M = 256;
   localparam int H = 128;

   typedef struct {
      logic [7:0] d;
      logic       c;
      logic       v;
   } res_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_op;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_carry;
   logic       out_ovf;
   logic [7:0] op_count;

   int   checks;
   int   failures;
   res_t q[$];
   int   m_acc;
   int   m_cnt;
   logic cur_v;
   int   cur_op;
   int   cur_a;
   int   cur_b;
   logic cur_ordy;

   tt_um_accum_alu #(.WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t calc(int op, int a, int b, int acc);
      res_t r;
      int   y, s, sa, sb, sr;
      y  = (op == int'(OP_ACC)) ? acc : b;
      sa = (a >= H) ? a - M : a;
      sb = (y >= H) ? y - M : y;
      r.d = 8'd0; r.c = 1'b0; r.v = 1'b0;
      if (op == int'(OP_ADD) || op == int'(OP_ACC)) begin
         s   = a + y;
         r.c = (s >= M);
         r.d = 8'(s % M);
         sr  = sa + sb;
         r.v = (sr > H - 1) || (sr < -H);
`ifdef ACCUM_ALU_SAT_EN
         if (r.c) r.d = 8'hFF;
`endif
      end else if (op == int'(OP_SUB)) begin
         s   = a - y;
         r.c = (a < y);
         r.d = 8'((s + M) % M);
         sr  = sa - sb;
         r.v = (sr > H - 1) || (sr < -H);
`ifdef ACCUM_ALU_SAT_EN
         if (r.c) r.d = 8'h00;
`endif
      end
      return r;
   endfunction

   task automatic drive(input logic v, input int op, input int a, input int b, input logic ordy);
      cur_v = v; cur_op = op; cur_a = a; cur_b = b; cur_ordy = ordy;
      in_valid  = v;
      in_op     = 2'(op);
      in_a      = 8'(a);
      in_b      = 8'(b);
      out_ready = ordy;
      #1;
   endtask

   task automatic advance();
      logic rdy;
      res_t r;
      rdy = (q.size() == 0) || cur_ordy;
      if (q.size() > 0 && cur_ordy) void'(q.pop_front());
      if (cur_v && rdy) begin
         r = calc(cur_op, cur_a, cur_b, m_acc);
         q.push_back(r);
         m_cnt = (m_cnt + 1) % M;
         if (cur_op == int'(OP_ACC) || cur_op == int'(OP_CLR)) m_acc = int'(r.d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      m_acc = 0;
      m_cnt = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
      #1 rst_n = 1'b0;
      model_reset();
      #2;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", out_data); end
      checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", op_count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
      @(posedge clk); #1 rst_n = 1'b1;
      drive(1'b1, int'(OP_ADD), 200, 100, 1'b0);
      advance();
      checks++; if (out_valid !== 1'b1 || out_data !== q[0].d) begin failures++; $display("FAIL pre_reset_full got=%0b/%0d exp=1/%0d", out_valid, out_data, q[0].d); end
      drive(1'b0, 0, 0, 0, 1'b0);
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (out_valid !== 1'b0 || out_carry !== 1'b0 || out_ovf !== 1'b0) begin failures++; $display("FAIL async_reset_flags got=%0b%0b%0b exp=000", out_valid, out_carry, out_ovf); end
      checks++; if (out_data !== 8'd0 || op_count !== 8'd0) begin failures++; $display("FAIL async_reset_data got=%0d/%0d exp=0/0", out_data, op_count); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", in_ready); end
      drive(1'b1, int'(OP_ACC), 5, 0, 1'b1);
      advance();
      checks++; if (out_data !== q[0].d || out_data !== 8'd5) begin failures++; $display("FAIL acc_after_reset got=%0d exp=%0d", out_data, q[0].d); end
   endtask

   task automatic test_add_sub();
      for (int i = 0; i < 40; i++) begin
         int op, a, b;
         op = (i % 2 == 0) ? int'(OP_ADD) : int'(OP_SUB);
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         if (i == 0) begin a = 200; b = 100; end
         if (i == 1) begin a = 5;   b = 7;   end
         if (i == 3) begin a = 128; b = 1;   end
         drive(1'b1, op, a, b, 1'b1);
         advance();
         checks++;
         if (out_valid !== 1'b1 || out_data !== q[0].d || out_carry !== q[0].c || out_ovf !== q[0].v)
         begin
            failures++;
            $display("FAIL addsub op=%0d a=%0d b=%0d got=%0b/%0d/%0b/%0b exp=1/%0d/%0b/%0b",
                     op, a, b, out_valid, out_data, out_carry, out_ovf, q[0].d, q[0].c, q[0].v);
         end
      end
      checks++; if (op_count !== 8'(m_cnt)) begin failures++; $display("FAIL addsub_count got=%0d exp=%0d", op_count, m_cnt); end
   endtask

   task automatic test_acc();
      for (int i = 0; i < 30; i++) begin
         int op, a;
         if (i == 0 || i == 15) op = int'(OP_CLR);
         else if (i < 4) op = int'(OP_ACC);
         else op = int'($urandom_range(0, 3));
         a = (i < 4) ? 100 : int'($urandom_range(0, 255));
         drive(1'b1, op, a, int'($urandom_range(0, 255)), 1'b1);
         advance();
         checks++;
         if (out_data !== q[0].d || out_carry !== q[0].c || out_ovf !== q[0].v) begin
            failures++;
            $display("FAIL acc step=%0d op=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                     i, op, out_data, out_carry, out_ovf, q[0].d, q[0].c, q[0].v);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] held;
      logic [7:0] cnt_held;
      drive(1'b1, int'(OP_ADD), 10, 1, 1'b0);
      advance();
      held = out_data;
      cnt_held = op_count;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, int'(OP_ADD), 20 + i, 1, 1'b0);
         checks++; if (in_ready !== ((q.size() == 0) || cur_ordy)) begin failures++; $display("FAIL bp_ready got=%0b exp=0", in_ready); end
         advance();
         checks++;
         if (out_valid !== 1'b1 || out_data !== held || out_data !== q[0].d || op_count !== cnt_held) begin
            failures++;
            $display("FAIL bp_hold got=%0b/%0d/%0d exp=1/%0d/%0d", out_valid, out_data, op_count, held, cnt_held);
         end
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, int'(OP_ADD), 40 + i, 1, 1'b1);
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
         advance();
         checks++;
         if (out_valid !== 1'b1 || out_data !== q[0].d || op_count !== 8'(m_cnt) || q.size() != 1) begin
            failures++;
            $display("FAIL b2b beat=%0d got=%0d/%0d exp=%0d/%0d", i, out_data, op_count, q[0].d, m_cnt);
         end
      end
      drive(1'b0, 0, 0, 0, 1'b1);
      advance();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0b exp=0", out_valid); end
   endtask

   task automatic test_count_wrap();
      logic [7:0] cnt_idle;
      rst_n = 1'b0;
      model_reset();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
         advance();
         if (i == 254) begin
            checks++; if (op_count !== 8'd255) begin failures++; $display("FAIL count_255 got=%0d exp=255", op_count); end
         end
      end
      checks++; if (op_count !== 8'(m_cnt) || op_count !== 8'd0) begin failures++; $display("FAIL count_wrap got=%0d exp=0", op_count); end
      cnt_idle = op_count;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, int'(OP_ACC), 99, 99, 1'b1);
         advance();
      end
      checks++; if (op_count !== cnt_idle || out_valid !== 1'b0) begin failures++; $display("FAIL idle got=%0d/%0b exp=%0d/0", op_count, out_valid, cnt_idle); end
      drive(1'b1, int'(OP_ACC), 0, 0, 1'b1);
      advance();
      checks++; if (out_data !== q[0].d) begin failures++; $display("FAIL idle_acc got=%0d exp=%0d", out_data, q[0].d); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_add_sub();
      test_acc();
      test_backpressure();
      test_count_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
